// File: rtl/dmem_lsu.sv
// Load/store initiator between the pipeline memory stage and a word-only dmem port.
// Sub-word stores are done as read-modify-write; loads are lane-selected and sign/zero-extended.
module dmem_lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [2:0]        dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // the producer holds req_valid until then. resp_valid is a single-cycle pulse
  // with no backpressure.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STORE  = 3'd2,
    S_RMW_RD = 3'd3,
    S_RMW_WR = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_we_q;
  logic [1:0]          r_size_q;
  logic                r_unsigned_q;
  logic [ADDR_W-1:0]   r_addr_q;
  logic [31:0]         r_wdata_q;
  logic                r_err_q;
  logic [31:0]         r_rdata_q;
  logic [31:0]         r_merge_q;

  logic                w_hs;
  logic                w_req_err;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [31:0]         w_load;
  logic [31:0]         w_merge;

  assign w_hs      = req_valid && req_ready;
  assign w_req_err = (req_size == 2'd3) ||
                     ((req_size == 2'd1) && req_addr[0]) ||
                     ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));

  // Lane extraction for loads and lane replacement for sub-word stores.
  always_comb begin
    w_byte  = 8'h00;
    w_merge = mem_rdata;
    case (r_addr_q[1:0])
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = r_addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_size_q)
      2'd0:    w_load = r_unsigned_q ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'd1:    w_load = r_unsigned_q ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load = mem_rdata;
    endcase
    if (r_size_q == 2'd0) begin
      case (r_addr_q[1:0])
        2'd0:    w_merge[7:0]   = r_wdata_q[7:0];
        2'd1:    w_merge[15:8]  = r_wdata_q[7:0];
        2'd2:    w_merge[23:16] = r_wdata_q[7:0];
        default: w_merge[31:24] = r_wdata_q[7:0];
      endcase
    end else if (r_addr_q[1]) begin
      w_merge[31:16] = r_wdata_q[15:0];
    end else begin
      w_merge[15:0] = r_wdata_q[15:0];
    end
  end

  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = 32'h0;
    case (r_state)
      S_IDLE: begin
        req_ready = !rst;
        if (w_hs) begin
          if (w_req_err)              w_next = S_RESP;
          else if (!req_we)           w_next = S_LOAD;
          else if (req_size == 2'd2)  w_next = S_STORE;
          else                        w_next = S_RMW_RD;
        end
      end
      S_LOAD:   w_next = S_RESP;
      S_STORE: begin
        mem_we    = !rst;
        mem_wdata = r_wdata_q;
        w_next    = S_RESP;
      end
      S_RMW_RD: w_next = S_RMW_WR;
      S_RMW_WR: begin
        mem_we    = !rst;
        mem_wdata = r_merge_q;
        w_next    = S_RESP;
      end
      S_RESP: begin
        resp_valid = !rst;
        w_next     = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_we_q       <= 1'b0;
      r_size_q     <= 2'd0;
      r_unsigned_q <= 1'b0;
      r_addr_q     <= '0;
      r_wdata_q    <= 32'h0;
      r_err_q      <= 1'b0;
      r_rdata_q    <= 32'h0;
      r_merge_q    <= 32'h0;
    end else begin
      r_state <= w_next;
      if (w_hs) begin
        r_we_q       <= req_we;
        r_size_q     <= req_size;
        r_unsigned_q <= req_unsigned;
        r_addr_q     <= req_addr;
        r_wdata_q    <= req_wdata;
        r_err_q      <= w_req_err;
        r_rdata_q    <= 32'h0;
      end
      if (r_state == S_LOAD)   r_rdata_q <= w_load;
      if (r_state == S_RMW_RD) r_merge_q <= w_merge;
    end
  end

  // rdata_q stays 0 for stores and errors because it is cleared at capture.
  assign resp_rdata = resp_valid ? r_rdata_q : 32'h0;
  assign resp_err   = resp_valid && r_err_q;
  assign mem_addr   = {r_addr_q[ADDR_W-1:2], 2'b00};
  assign dbg_state  = r_state;

endmodule
